display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a bank of common-anode 7-segment digits. It holds a multi-nibble value, steps through the digits at a programmable rate, and drives one 4-bit nibble plus a one-hot active-low digit enable. The nibble feeds the existing hex-to-7-segment decoder, whose SEG output is shared by all digits. Value updates use a load/acknowledge handshake and are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/display_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexing scan controller for a bank of common-anode 7-segment
//   digits. It holds a multi-nibble value and steps through the digits at a
//   programmable rate. Each slot drives one nibble to the shared hex decoder
//   and one active-low digit enable. New values are loaded through a
//   load/acknowledge handshake and are only shown from a frame boundary on.
//
// Ports
//   CLK         system clock, rising edge
//   RESETN      asynchronous active-low reset
//   EN          scan enable (0 = display off)
//   LZ_BLANK    1 = suppress leading zeros
//   VALUE       value to display, digit i = VALUE[4i+3:4i]
//   LOAD        single-cycle strobe that captures VALUE
//   ACK         one-cycle pulse when a captured value becomes displayed
//   FRAME_DONE  one-cycle pulse after the last digit's slot
//   DISPLAYWIRE nibble of the current digit
//   DIGIT_EN    active-low one-hot digit enable
module display_scan_ctrl #(
   parameter int NDIGITS  = 8,
   parameter int PRESCALE = 50000
) (
   input  logic                   CLK,
   input  logic                   RESETN,
   input  logic                   EN,
   input  logic                   LZ_BLANK,
   input  logic [4*NDIGITS-1:0]   VALUE,
   input  logic                   LOAD,
   output logic                   ACK,
   output logic                   FRAME_DONE,
   output logic [3:0]             DISPLAYWIRE,
   output logic [NDIGITS-1:0]     DIGIT_EN
);

   localparam int IW = $clog2(NDIGITS);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);
   localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);

   typedef enum logic {ST_OFF, ST_SCAN} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        pre_q, pre_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [4*NDIGITS-1:0] active_q, active_d;
   logic [4*NDIGITS-1:0] pending_q, pending_d;
   logic                 pend_flag_q, pend_flag_d;
   logic                 ack_q, ack_d;
   logic                 fd_q, fd_d;

   logic                 tick;
   logic                 wrap;
   logic                 xfer;
   logic [3:0]           cur_nib;
   logic                 upper_zero;
   logic                 blank;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= ST_OFF;
         pre_q       <= '0;
         idx_q       <= '0;
         active_q    <= '0;
         pending_q   <= '0;
         pend_flag_q <= 1'b0;
         ack_q       <= 1'b0;
         fd_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         idx_q       <= idx_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         pend_flag_q <= pend_flag_d;
         ack_q       <= ack_d;
         fd_q        <= fd_d;
      end
   end

   // Next-state, prescaler, digit index and load handshake.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      idx_d   = idx_q;
      tick    = (state_q == ST_SCAN) && (pre_q == LAST_PRE);
      wrap    = tick && (idx_q == LAST_IDX);

      case (state_q)
         ST_OFF: begin
            if (EN) begin
               state_d = ST_SCAN;
               pre_d   = '0;
               idx_d   = '0;
            end
         end
         ST_SCAN: begin
            if (!EN) begin
               state_d = ST_OFF;
               pre_d   = '0;
               idx_d   = '0;
            end else if (tick) begin
               pre_d = '0;
               idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_OFF;
            pre_d   = '0;
            idx_d   = '0;
         end
      endcase

      // While off, a pending value is applied immediately; while scanning,
      // only at the frame wrap so a frame never mixes old and new digits.
      xfer     = pend_flag_q && ((state_q == ST_OFF) || wrap);
      active_d = xfer ? pending_q : active_q;
      ack_d    = xfer;
      fd_d     = wrap;

      // A LOAD coinciding with a transfer re-arms the flag: the old pending
      // value moves to active and the new one waits for the next wrap.
      pending_d   = LOAD ? VALUE : pending_q;
      pend_flag_d = LOAD ? 1'b1 : (xfer ? 1'b0 : pend_flag_q);
   end

   // Digit outputs, derived only from registered state.
   always_comb begin
      DISPLAYWIRE = '0;
      DIGIT_EN    = '1;
      cur_nib     = '0;
      upper_zero  = 1'b1;

      for (int unsigned i = 0; i < NDIGITS; i++) begin
         if (idx_q == IW'(i))
            cur_nib = active_q[4*i +: 4];
         if ((IW'(i) >= idx_q) && (active_q[4*i +: 4] != 4'h0))
            upper_zero = 1'b0;
      end

      // Digit 0 is never blanked so an all-zero value still shows "0".
      blank = LZ_BLANK && (idx_q != '0) && upper_zero;

      if (state_q == ST_SCAN) begin
         DISPLAYWIRE = cur_nib;
         for (int unsigned i = 0; i < NDIGITS; i++) begin
            if ((idx_q == IW'(i)) && !blank)
               DIGIT_EN[i] = 1'b0;
         end
      end
   end

   assign ACK        = ack_q;
   assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Self-checking bench for display_scan_ctrl with NDIGITS=4, PRESCALE=3.
//   A table of {inputs, repeat count, expected outputs} records is applied
//   one clock edge at a time; outputs are sampled 1 time unit after each
//   rising edge. Reset behaviour is exercised by hand-written sequences.
module tb_display_scan_ctrl;

   localparam int ND = 4;
   localparam int PS = 3;

   logic          clk;
   logic          resetn;
   logic          en;
   logic          lz_blank;
   logic [15:0]   value;
   logic          load;
   logic          ack;
   logic          frame_done;
   logic [3:0]    displaywire;
   logic [3:0]    digit_en;

   int checks;
   int errors;

   typedef struct {
      int          n;
      logic        en;
      logic        lz;
      logic        load;
      logic [15:0] value;
      logic [3:0]  de;
      logic [3:0]  dw;
      logic        ack;
      logic        fd;
   } vec_t;

   vec_t vecs[$];

   display_scan_ctrl #(
      .NDIGITS  (ND),
      .PRESCALE (PS)
   ) dut (
      .CLK         (clk),
      .RESETN      (resetn),
      .EN          (en),
      .LZ_BLANK    (lz_blank),
      .VALUE       (value),
      .LOAD        (load),
      .ACK         (ack),
      .FRAME_DONE  (frame_done),
      .DISPLAYWIRE (displaywire),
      .DIGIT_EN    (digit_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int k, input logic [3:0] act,
                      input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %h want %h", nm, k, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int k, input logic [3:0] de,
                          input logic [3:0] dw, input logic a, input logic fd);
      chk({tag, ".digit_en"},    k, digit_en,           de);
      chk({tag, ".displaywire"}, k, displaywire,        dw);
      chk({tag, ".ack"},         k, {3'b000, ack},        {3'b000, a});
      chk({tag, ".frame_done"},  k, {3'b000, frame_done}, {3'b000, fd});
   endtask

   task automatic add(input int n, input logic e, input logic lz, input logic ld,
                      input logic [15:0] v, input logic [3:0] de,
                      input logic [3:0] dw, input logic a, input logic fd);
      vec_t r;
      r.n = n; r.en = e; r.lz = lz; r.load = ld; r.value = v;
      r.de = de; r.dw = dw; r.ack = a; r.fd = fd;
      vecs.push_back(r);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      resetn   = 1'b0;
      en       = 1'b0;
      lz_blank = 1'b0;
      value    = '0;
      load     = 1'b0;

      //   n  en lz ld value     de     dw   ack fd
      // Load while off, then a full scan of 1A3F
      add(1, 0, 0, 1, 16'h1A3F, 4'hF, 4'h0, 0, 0);
      add(1, 0, 0, 0, 16'h0000, 4'hF, 4'h0, 1, 0);
      add(1, 0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hE, 4'hF, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hD, 4'h3, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hB, 4'hA, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'h7, 4'h1, 0, 0);
      add(1, 1, 0, 0, 16'h0000, 4'hE, 4'hF, 0, 1);
      add(2, 1, 0, 0, 16'h0000, 4'hE, 4'hF, 0, 0);
      // Mid-frame load of 0007 at idx1
      add(1, 1, 0, 0, 16'h0000, 4'hD, 4'h3, 0, 0);
      add(1, 1, 0, 1, 16'h0007, 4'hD, 4'h3, 0, 0);
      add(1, 1, 0, 0, 16'h0000, 4'hD, 4'h3, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hB, 4'hA, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'h7, 4'h1, 0, 0);
      add(1, 1, 0, 0, 16'h0000, 4'hE, 4'h7, 1, 1);
      add(2, 1, 0, 0, 16'h0000, 4'hE, 4'h7, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hD, 4'h0, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hB, 4'h0, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'h7, 4'h0, 0, 0);
      // Leading-zero blanking of 0007
      add(1, 1, 1, 0, 16'h0000, 4'hE, 4'h7, 0, 1);
      add(2, 1, 1, 0, 16'h0000, 4'hE, 4'h7, 0, 0);
      add(9, 1, 1, 0, 16'h0000, 4'hF, 4'h0, 0, 0);
      // Load on a wrap with nothing pending: waits a whole frame
      add(1, 1, 1, 1, 16'h0000, 4'hE, 4'h7, 0, 1);
      add(2, 1, 1, 0, 16'h0000, 4'hE, 4'h7, 0, 0);
      add(9, 1, 1, 0, 16'h0000, 4'hF, 4'h0, 0, 0);
      // Load on the transfer edge: 0000 shown now, 0300 next frame
      add(1, 1, 1, 1, 16'h0300, 4'hE, 4'h0, 1, 1);
      add(2, 1, 1, 0, 16'h0000, 4'hE, 4'h0, 0, 0);
      add(9, 1, 1, 0, 16'h0000, 4'hF, 4'h0, 0, 0);
      add(1, 1, 1, 0, 16'h0000, 4'hE, 4'h0, 1, 1);
      add(2, 1, 1, 0, 16'h0000, 4'hE, 4'h0, 0, 0);
      add(3, 1, 1, 0, 16'h0000, 4'hD, 4'h0, 0, 0);
      add(3, 1, 1, 0, 16'h0000, 4'hB, 4'h3, 0, 0);
      add(3, 1, 1, 0, 16'h0000, 4'hF, 4'h0, 0, 0);
      // Overwritten loads: 1111 dropped, 2222 shown, 3333 on wrap edge
      add(1, 1, 0, 0, 16'h0000, 4'hE, 4'h0, 0, 1);
      add(1, 1, 0, 1, 16'h1111, 4'hE, 4'h0, 0, 0);
      add(1, 1, 0, 0, 16'h0000, 4'hE, 4'h0, 0, 0);
      add(1, 1, 0, 1, 16'h2222, 4'hD, 4'h0, 0, 0);
      add(2, 1, 0, 0, 16'h0000, 4'hD, 4'h0, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hB, 4'h3, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'h7, 4'h0, 0, 0);
      add(1, 1, 0, 1, 16'h3333, 4'hE, 4'h2, 1, 1);
      add(2, 1, 0, 0, 16'h0000, 4'hE, 4'h2, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hD, 4'h2, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hB, 4'h2, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'h7, 4'h2, 0, 0);
      add(1, 1, 0, 0, 16'h0000, 4'hE, 4'h3, 1, 1);
      add(2, 1, 0, 0, 16'h0000, 4'hE, 4'h3, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hD, 4'h3, 0, 0);
      // EN drop at idx2, then restart with a full slot at idx0
      add(1, 1, 0, 0, 16'h0000, 4'hB, 4'h3, 0, 0);
      add(1, 0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0);
      add(2, 0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hE, 4'h3, 0, 0);
      add(3, 1, 0, 0, 16'h0000, 4'hD, 4'h3, 0, 0);

      // Reset state after power-up
      repeat (2) @(posedge clk);
      #1;
      chk_all("por", 0, 4'hF, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      resetn = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         en       = vecs[k].en;
         lz_blank = vecs[k].lz;
         value    = vecs[k].value;
         for (int c = 0; c < vecs[k].n; c++) begin
            load = (c == 0) ? vecs[k].load : 1'b0;
            @(posedge clk);
            #1;
            chk_all("vec", k, vecs[k].de, vecs[k].dw, vecs[k].ack, vecs[k].fd);
         end
         load = 1'b0;
      end

      // Asynchronous reset mid-scan: outputs clear at once and hold
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk_all("rst_now", 0, 4'hF, 4'h0, 1'b0, 1'b0);
      for (int c = 1; c <= 2; c++) begin
         @(posedge clk);
         #1;
         chk_all("rst_hold", c, 4'hF, 4'h0, 1'b0, 1'b0);
      end
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk_all("rst_rel", 0, 4'hF, 4'h0, 1'b0, 1'b0);
      // EN still high: scanning restarts at idx0 with a cleared value
      for (int c = 0; c < PS; c++) begin
         @(posedge clk);
         #1;
         chk_all("post_rst", c, 4'hE, 4'h0, 1'b0, 1'b0);
      end
      @(posedge clk);
      #1;
      chk_all("post_rst", PS, 4'hD, 4'h0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
